// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Shares one external memory bus between instruction fetch (IF) and the
//   data-memory stage (MEM). One bus transaction at a time: IDLE grants,
//   BUSY waits for bus_ack_i, DONE pulses the owner's ack for one cycle.
//   Ties alternate against the previous owner (MEM wins the first tie).
//   A flush during an IF transaction lets the bus cycle finish but drops
//   the fetched word and its ack.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   -> a BUSY-cycle counter aborts after TIMEOUT_CYCLES cycles
//                without bus_ack_i, loads 0 into the owner's data register
//                and pulses bus_err_o together with the owner's ack.
//   Undefined -> BUSY waits indefinitely, bus_err_o is tied 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req_i/if_addr_i       IF read request and fetch address
//   if_data_o/if_ack_o       fetched word and one-cycle completion pulse
//   mem_req_i/mem_we_i/mem_sel_i/mem_addr_i/mem_data_i  MEM access request
//   mem_data_o/mem_ack_o     load data and one-cycle completion pulse
//   flush_i                  pipeline flush from ctrl
//   bus_ce_o/bus_we_o/bus_sel_o/bus_addr_o/bus_data_o   bus master outputs
//   bus_data_i/bus_ack_i     bus read data and completion
//   bus_err_o                timeout pulse
//   stallreq_if_o/stallreq_mem_o  per-stage stall requests to ctrl
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ack_o,
    input  logic              flush_i,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_t state, state_nxt;
    logic   owner, last_owner;
    logic   drop;          // current IF transaction was flushed
    logic   if_cand, mem_cand, grant_any, grant_mem;
    logic   timeout_hit;

    // A flushed IF request is not a candidate; MEM always is.
    assign if_cand   = if_req_i & ~flush_i;
    assign mem_cand  = mem_req_i;
    assign grant_any = if_cand | mem_cand;
    // On a tie the requester that did not own the bus last time wins.
    assign grant_mem = mem_cand & (~if_cand | (last_owner == OWN_IF));

    assign if_ack_o  = (state == DONE) && (owner == OWN_IF) && !drop;
    assign mem_ack_o = (state == DONE) && (owner == OWN_MEM);

    assign stallreq_if_o  = if_req_i & ~if_ack_o & ~flush_i;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt;
    logic             err;

    // Abort on the cycle the count would reach TIMEOUT_CYCLES.
    assign timeout_hit = (state == BUSY) && !bus_ack_i &&
                         (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err_o   = (state == DONE) && err;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    err <= 1'b0;
                end
                BUSY: begin
                    if (!bus_ack_i) cnt <= cnt + 1'b1;
                    if (timeout_hit) err <= 1'b1;
                end
                default: err <= 1'b0;
            endcase
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = BUSY;
            BUSY:    if (bus_ack_i || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            drop       <= 1'b0;
            bus_ce_o   <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_sel_o  <= 4'b0000;
            bus_addr_o <= '0;
            bus_data_o <= '0;
            if_data_o  <= '0;
            mem_data_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_any) begin
                        owner    <= grant_mem;
                        bus_ce_o <= 1'b1;
                        if (grant_mem) begin
                            bus_we_o   <= mem_we_i;
                            bus_sel_o  <= mem_sel_i;
                            bus_addr_o <= mem_addr_i;
                            bus_data_o <= mem_data_i;
                        end else begin
                            bus_we_o   <= 1'b0;
                            bus_sel_o  <= 4'b1111;
                            bus_addr_o <= if_addr_i;
                            bus_data_o <= '0;
                        end
                    end
                end
                BUSY: begin
                    if ((owner == OWN_IF) && flush_i) drop <= 1'b1;
                    if (bus_ack_i || timeout_hit) begin
                        bus_ce_o   <= 1'b0;
                        last_owner <= owner;
                        // A flush in the completing cycle also drops the word.
                        if (owner == OWN_IF) begin
                            if (!drop && !flush_i)
                                if_data_o <= bus_ack_i ? bus_data_i : '0;
                        end else if (!bus_ack_i) begin
                            mem_data_o <= '0;
                        end else if (!bus_we_o) begin
                            mem_data_o <= bus_data_i;
                        end
                    end
                end
                DONE:    drop <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external memory bus port between instruction fetch (IF) and the data-memory stage (MEM) of the 5-stage pipeline.
- Sequences one bus transaction at a time.
- Returns read data and a one-cycle ack to the owning requester.
- Raises per-stage stall requests into ctrl until that stage's access completes.

Parameters:
ADDR_W, 32, address width of all address ports.
DATA_W, 32, data width of all data ports.
TIMEOUT_CYCLES, 255, BUSY cycles without bus_ack_i before abort (used only with BUS_TIMEOUT_EN).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high (1 = reset)
if_req_i  input  1  IF read request, held until if_ack_o
if_addr_i  input  ADDR_W  IF fetch address
if_data_o  output  DATA_W  fetched instruction, valid when if_ack_o=1
if_ack_o  output  1  one-cycle completion pulse for IF
mem_req_i  input  1  MEM access request, held until mem_ack_o
mem_we_i  input  1  1 = write, 0 = read
mem_sel_i  input  4  byte lane select
mem_addr_i  input  ADDR_W  MEM address
mem_data_i  input  DATA_W  store data
mem_data_o  output  DATA_W  load data, valid when mem_ack_o=1
mem_ack_o  output  1  one-cycle completion pulse for MEM
flush_i  input  1  pipeline flush from ctrl
bus_ce_o  output  1  bus cycle active
bus_we_o  output  1  bus write enable
bus_sel_o  output  4  bus byte select
bus_addr_o  output  ADDR_W  bus address
bus_data_o  output  DATA_W  bus write data
bus_data_i  input  DATA_W  bus read data, valid with bus_ack_i
bus_ack_i  input  1  bus completion, sampled only in BUSY
bus_err_o  output  1  timeout pulse; tied 0 without BUS_TIMEOUT_EN
stallreq_if_o  output  1  IF stall request to ctrl
stallreq_mem_o  output  1  MEM stall request to ctrl

Behaviour:
- Reset:
  - state=IDLE, owner=IF, last_owner=IF.
  - All outputs 0; if_data_o and mem_data_o = 0.
  - Reset mid-transaction abandons it: bus_ce_o=0 from the next edge, no ack issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - bus_ce_o=0.
  - Candidates: mem_req_i, and if_req_i only when flush_i=0.
  - Exactly one candidate: grant it.
  - Both candidates: grant the one not equal to last_owner. After reset MEM wins the first tie.
  - On grant: register owner; load bus_we/sel/addr/data from the winner; bus_ce_o=1; go BUSY.
  - IF grants drive bus_we_o=0, bus_sel_o=4'b1111, bus_data_o=0.
- BUSY:
  - Bus outputs held stable.
  - On bus_ack_i=1 (read):
    - IF owner: bus_data_i is captured into if_data_o.
    - MEM owner with we=0: bus_data_i is captured into mem_data_o.
    - MEM writes leave mem_data_o unchanged.
  - Also on bus_ack_i=1: bus_ce_o=0, last_owner=owner, go DONE.
- DONE:
  - The owner's ack_o = 1 for exactly this cycle; then go IDLE.
  - No new grant is made in DONE.
- Latency: request sampled in IDLE at cycle 0; bus_ce_o=1 at cycle 1; ack_o at cycle N+1, where bus_ack_i arrives at cycle N ≥ 1. Minimum 2 cycles.
- Stall requests are combinational: stallreq_if_o = if_req_i & ~if_ack_o & ~flush_i; stallreq_mem_o = mem_req_i & ~mem_ack_o.
- Flush:
  - flush_i=1 while owner=IF in BUSY sets a drop flag.
  - The bus cycle still completes, but if_ack_o is suppressed and if_data_o is not updated.
  - The drop flag clears on entering IDLE.
  - MEM transactions are never affected by flush_i.
- if_data_o and mem_data_o hold their value between completions.
- bus_ack_i outside BUSY is ignored.
- A requester dropping req mid-BUSY does not abort the cycle. Its ack still pulses and is ignored by the pipeline.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined:
  - An 8+ bit counter clears on entering BUSY and increments each BUSY cycle without bus_ack_i.
  - When it reaches TIMEOUT_CYCLES: bus_ce_o=0; the owner's data register loads 0; bus_err_o pulses 1 for one cycle together with the DONE-state ack; last_owner updates as usual.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o constant 0.

Test Plan:
- Reset, then IF req addr 0x0000_0100; bus_ack_i one cycle after bus_ce_o with data 0x3401_1100 -> bus_addr_o=0x100, bus_we_o=0; if_data_o=0x3401_1100 and if_ack_o=1 two cycles after the req was sampled; stallreq_if_o=1 until then.
- IF and MEM req in the same IDLE cycle right after reset, MEM write 0xDEAD_BEEF to 0x80, sel 4'b0011 -> MEM granted first (bus_we_o=1, bus_sel_o=0011); IF granted next; each ack is a single pulse.
- Two back-to-back ties -> grants alternate MEM, IF, MEM, IF.
- MEM load from 0x40 with 3-cycle bus latency returning 0x0000_00FF -> bus outputs stable for 3 cycles; mem_data_o=0xFF with mem_ack_o exactly one cycle; stallreq_mem_o=1 for the 4 preceding cycles.
- flush_i=1 during an IF BUSY cycle -> bus cycle completes, if_ack_o stays 0, if_data_o keeps its prior value; a MEM access with flush_i=1 still acks.
- rst=1 mid-BUSY -> next cycle all outputs 0, state IDLE. With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no bus_ack_i -> bus_err_o and the owner's ack pulse together, data=0.
